fft_pingpong_ctrl: RTL and testbench
====================================

# fft_pingpong_ctrl

Ping-pong bank controller for the FFT input path. Counts accepted input beats into frames of `FRAME_LEN` 136-bit samples and drives the select of the existing two-way data demux. It alternates frames between bank A (demux output 1) and bank B (demux output 2). It tracks which bank holds a complete frame and stalls the upstream source when both banks are full until the FFT core releases one.

## Interface
Parameters:
- `FRAME_LEN`, 16: samples per frame; power of two, 2 to 1024.
- `CNT_W`, 4: write-address width; must equal log2(`FRAME_LEN`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: controller accepts a sample this cycle. A beat is accepted when `in_valid && in_ready`.
- `bank_release` in 2: single-cycle pulse from the FFT core. Bit 0 frees bank A; bit 1 frees bank B.
- `demux_flag` out 1: demux select. 1 routes to bank A (`data_out_1`); 0 routes to bank B (`data_out_2`).
- `wr_en` out 2: per-bank write strobe. Bit 0 is bank A; bit 1 is bank B.
- `wr_addr` out `CNT_W`: sample index within the frame.
- `bank_full` out 2: bank holds a complete, unreleased frame.
- `frame_done` out 1: one-cycle pulse, one cycle after the last beat of a frame is accepted.
- `err` out 1: sticky protocol error; see Configuration.

## Operation
States are IDLE, FILL and STALL. The active bank is A when `demux_flag` is 1 and B when it is 0.

Reset values:
- State is IDLE.
- `demux_flag` is 1.
- Count, `wr_addr`, `bank_full`, `frame_done` and `err` are 0.
- `in_ready` and `wr_en` are 0.

IDLE:
- `in_ready` is 0.
- Goes to FILL unconditionally on the next cycle.

FILL:
- `in_ready` is 1.
- `wr_en[active] = in_valid` (combinational). The other `wr_en` bit is 0.
- `wr_addr` is the count register.
- Count increments on each accepted beat.
- When the accepted beat has count = `FRAME_LEN-1`:
  - count wraps to 0;
  - `bank_full[active]` is set;
  - `frame_done` pulses on the next cycle.
- On that same last beat:
  - If the other bank is not full, or is being released this cycle, toggle `demux_flag` and stay in FILL.
  - Otherwise keep `demux_flag` and go to STALL.

STALL:
- `in_ready` is 0 and `wr_en` is 00.
- If the other bank is released, toggle `demux_flag` and go to FILL. If both banks are released in the same cycle, this rule applies and alternation is preserved.
- Else if the active bank is released, keep `demux_flag` and go to FILL.

`bank_release[i]`:
- Clears `bank_full[i]` on the next edge.
- If the release coincides with a set of the same bit, the set wins. This cannot occur under a legal protocol.

A release of a non-full bank is ignored (it sets `err` when the error feature is enabled).

`demux_flag` changes only at frame boundaries. The demux zeroes the deselected output, so a mid-frame toggle is forbidden.

## Timing
- Write latency is 0: `wr_en` and `wr_addr` are valid in the same cycle as the accepted beat.
- `demux_flag`, `bank_full` and state are registered. They update on the edge after the last beat of a frame.
- Back-to-back frames need no bubble when the other bank is free: the first beat of the next frame can be accepted the cycle after the last beat of the previous frame.
- Release to resume from STALL takes 1 cycle: `in_ready` is high the cycle after the `bank_release` pulse.
- `rst` asserted mid-frame aborts the frame. All outputs return to reset values on that edge and partial frames are discarded.

## Configuration
- `FFT_PP_ERR_EN` defined:
  - `err` is set, and stays set until `rst`, on a `bank_release` of a bank whose `bank_full` is 0.
  - `err` is also set on `in_valid` high while the state is STALL (an overrun attempt).
- `FFT_PP_ERR_EN` undefined: `err` is tied to 0 and no error logic is built.

## Test plan
- Reset, then 16 continuous valid beats with `FRAME_LEN`=16: `wr_en`=01 and `wr_addr` runs 0..15. Next cycle `demux_flag`=0, `bank_full`=01, `frame_done` pulses once.
- 32 continuous beats with no release: bank B fills with `wr_en`=10 and no bubble. Then `bank_full`=11, `in_ready`=0, state is STALL, and `demux_flag` stays 0.
- In STALL, pulse `bank_release`=01: the next cycle `demux_flag`=1, `in_ready`=1, `bank_full`=10, and the next beat writes bank A at address 0.
- In STALL, pulse `bank_release`=11: `demux_flag` toggles, `bank_full`=00, and filling resumes.
- On the last beat of bank B while bank A is full, pulse `bank_release`=01 in the same cycle: no stall, `demux_flag`=1 the next cycle.
- Assert `rst` at beat 7, then release it: `wr_addr`=0, `bank_full`=00, `demux_flag`=1. With `FFT_PP_ERR_EN`, a `bank_release`=10 while `bank_full`=00 sets `err`=1 permanently.

Source files
------------

// File: rtl/fft_pingpong_ctrl.sv
// fft_pingpong_ctrl
// Ping-pong bank controller for the FFT input path. Counts accepted beats into
// frames of FRAME_LEN samples, steers the two-way data demux between bank A
// (o_demux_flag = 1) and bank B (o_demux_flag = 0), tracks which banks hold a
// complete frame and stalls the source while both banks are full.
//
// Optional feature macro: FFT_PP_ERR_EN
//   defined   : o_err is a sticky flag set by a release of a non-full bank or
//               by i_in_valid while stalled; cleared only by i_rst.
//   undefined : o_err is tied low and no error logic is built.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | one cycle after reset, source held off
// S_FILL  | accepting beats into the active bank
// S_STALL | both banks full, waiting for the FFT core to release one

module fft_pingpong_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_bank_release,
  output logic             o_demux_flag,
  output logic [1:0]       o_wr_en,
  output logic [CNT_W-1:0] o_wr_addr,
  output logic [1:0]       o_bank_full,
  output logic             o_frame_done,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_demux_flag;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_bank_full;
  logic             r_frame_done;

  logic [1:0]       w_active_oh;
  logic [1:0]       w_other_oh;
  logic             w_accept;
  logic             w_last_beat;
  logic             w_other_rel;
  logic             w_active_rel;
  logic             w_other_free;
  logic [1:0]       w_bank_set;

  // Bank A is bit 0 of every per-bank vector, bank B is bit 1.
  assign w_active_oh  = r_demux_flag ? 2'b01 : 2'b10;
  assign w_other_oh   = ~w_active_oh;

  // r_in_ready is only ever high in S_FILL, so it doubles as the fill qualifier.
  assign w_accept     = i_in_valid && r_in_ready;
  assign w_last_beat  = w_accept && (r_count == LAST_IDX);

  assign w_other_rel  = |(i_bank_release & w_other_oh);
  assign w_active_rel = |(i_bank_release & w_active_oh);

  // A release landing on the same edge as the frame end lets the next frame
  // start without a stall.
  assign w_other_free = ~|(r_bank_full & w_other_oh) || w_other_rel;

  assign w_bank_set   = w_last_beat ? w_active_oh : 2'b00;

  // Zero-latency write strobe; the demux select is stable for the whole frame.
  always_comb begin
    o_wr_en = 2'b00;
    if (r_state == S_FILL && i_in_valid) begin
      o_wr_en = w_active_oh;
    end
  end

  assign o_wr_addr    = r_count;
  assign o_in_ready   = r_in_ready;
  assign o_demux_flag = r_demux_flag;
  assign o_bank_full  = r_bank_full;
  assign o_frame_done = r_frame_done;

  // Sequencing FSM: frame counting, bank alternation and stall/resume.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_demux_flag <= 1'b1;
      r_count      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_beat;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_count <= '0;
              if (w_other_free) begin
                r_demux_flag <= ~r_demux_flag;
              end else begin
                r_state    <= S_STALL;
                r_in_ready <= 1'b0;
              end
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_STALL: begin
          // Preferring the other bank keeps A/B alternation when both free up.
          if (w_other_rel) begin
            r_demux_flag <= ~r_demux_flag;
            r_state      <= S_FILL;
            r_in_ready   <= 1'b1;
          end else if (w_active_rel) begin
            r_state    <= S_FILL;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Bank occupancy: set by a completed frame, cleared by the core's release.
  // A set on the same edge as a release of that bank takes priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= (r_bank_full & ~i_bank_release) | w_bank_set;
    end
  end

`ifdef FFT_PP_ERR_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (|(i_bank_release & ~r_bank_full)) ||
                     ((r_state == S_STALL) && i_in_valid);

  // Sticky protocol error: spurious release or overrun attempt while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Directed bench for fft_pingpong_ctrl with FRAME_LEN = 16.
// Every step starts at a falling edge: registered outputs are checked there,
// inputs are then driven and combinational outputs checked 1 ns later.

module tb_fft_pingpong_ctrl;

`ifdef FFT_PP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] bank_release;
  logic       demux_flag;
  logic [1:0] wr_en;
  logic [3:0] wr_addr;
  logic [1:0] bank_full;
  logic       frame_done;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  fft_pingpong_ctrl #(
    .FRAME_LEN (16),
    .CNT_W     (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_bank_release (bank_release),
    .o_demux_flag   (demux_flag),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_bank_full    (bank_full),
    .o_frame_done   (frame_done),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sixteen back-to-back beats; rel_last is pulsed together with the last beat.
  // Starts and ends on a falling edge, leaving the inputs idle.
  task automatic fill_frame(input string tag, input logic [1:0] exp_wr_en,
                            input logic [1:0] rel_last);
    for (int i = 0; i < 16; i++) begin
      in_valid     = 1'b1;
      bank_release = (i == 15) ? rel_last : 2'b00;
      #1;
      chk({tag, "_wr_en"}, wr_en, exp_wr_en);
      chk({tag, "_wr_addr"}, wr_addr, i);
      chk({tag, "_in_ready"}, in_ready, 1);
      if (i == 1) chk({tag, "_frame_done_low"}, frame_done, 0);
      @(negedge clk);
    end
    in_valid     = 1'b0;
    bank_release = 2'b00;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    bank_release = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("rst_in_ready",   in_ready,   0);
    chk("rst_demux",      demux_flag, 1);
    chk("rst_wr_en",      wr_en,      0);
    chk("rst_wr_addr",    wr_addr,    0);
    chk("rst_bank_full",  bank_full,  0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err",        err,        0);

    rst = 1'b0;
    @(negedge clk);
    chk("idle_to_fill_ready", in_ready, 1);
    chk("idle_to_fill_demux", demux_flag, 1);

    // First frame into bank A.
    fill_frame("fa1", 2'b01, 2'b00);
    chk("fa1_demux",      demux_flag, 0);
    chk("fa1_full",       bank_full,  2'b01);
    chk("fa1_frame_done", frame_done, 1);
    chk("fa1_err",        err,        0);

    // Bank B fills with no bubble, then both banks full -> stall.
    fill_frame("fb1", 2'b10, 2'b00);
    in_valid = 1'b1;
    #1;
    chk("stall_full",       bank_full,  2'b11);
    chk("stall_in_ready",   in_ready,   0);
    chk("stall_demux",      demux_flag, 0);
    chk("stall_frame_done", frame_done, 1);
    chk("stall_wr_en",      wr_en,      2'b00);
    @(negedge clk);
    chk("stall_hold_ready", in_ready,   0);
    chk("stall_overrun_err", err,       ERR_EN);
    chk("stall_frame_done_low", frame_done, 0);

    // Release of the other bank (A) from stall: toggle to A.
    in_valid     = 1'b0;
    bank_release = 2'b01;
    @(negedge clk);
    bank_release = 2'b00;
    chk("relA_demux",    demux_flag, 1);
    chk("relA_in_ready", in_ready,   1);
    chk("relA_full",     bank_full,  2'b10);

    fill_frame("fa2", 2'b01, 2'b00);
    chk("fa2_full",     bank_full,  2'b11);
    chk("fa2_in_ready", in_ready,   0);
    chk("fa2_demux",    demux_flag, 1);

    // Release of the active bank only: resume without toggling.
    bank_release = 2'b01;
    @(negedge clk);
    bank_release = 2'b00;
    chk("relact_demux",    demux_flag, 1);
    chk("relact_in_ready", in_ready,   1);
    chk("relact_full",     bank_full,  2'b10);

    fill_frame("fa3", 2'b01, 2'b00);
    chk("fa3_full",     bank_full,  2'b11);
    chk("fa3_in_ready", in_ready,   0);

    // Both released together: alternation wins, move to B.
    bank_release = 2'b11;
    @(negedge clk);
    bank_release = 2'b00;
    chk("rel11_demux",    demux_flag, 0);
    chk("rel11_full",     bank_full,  2'b00);
    chk("rel11_in_ready", in_ready,   1);

    fill_frame("fb2", 2'b10, 2'b00);
    chk("fb2_demux",    demux_flag, 1);
    chk("fb2_full",     bank_full,  2'b10);
    chk("fb2_in_ready", in_ready,   1);

    fill_frame("fa4", 2'b01, 2'b00);
    chk("fa4_full",     bank_full,  2'b11);
    chk("fa4_in_ready", in_ready,   0);

    bank_release = 2'b10;
    @(negedge clk);
    bank_release = 2'b00;
    chk("relB_demux", demux_flag, 0);
    chk("relB_full",  bank_full,  2'b01);

    // Last beat of B coincides with release of A: no stall.
    fill_frame("fb3", 2'b10, 2'b01);
    chk("fb3_demux",      demux_flag, 1);
    chk("fb3_in_ready",   in_ready,   1);
    chk("fb3_full",       bank_full,  2'b10);
    chk("fb3_frame_done", frame_done, 1);

    // Reset mid-frame at beat 7 of bank A.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      #1;
      chk("part_wr_addr", wr_addr, i);
      @(negedge clk);
    end
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    chk("part_beat7_addr", wr_addr, 7);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mrst_wr_addr",    wr_addr,    0);
    chk("mrst_full",       bank_full,  2'b00);
    chk("mrst_demux",      demux_flag, 1);
    chk("mrst_in_ready",   in_ready,   0);
    chk("mrst_wr_en",      wr_en,      2'b00);
    chk("mrst_frame_done", frame_done, 0);
    chk("mrst_err",        err,        0);
    @(negedge clk);
    chk("mrst_resume_ready", in_ready, 1);

    // Spurious release of an empty bank.
    bank_release = 2'b10;
    @(negedge clk);
    bank_release = 2'b00;
    chk("badrel_err",  err,       ERR_EN);
    chk("badrel_full", bank_full, 2'b00);
    repeat (3) @(negedge clk);
    chk("badrel_err_sticky", err, ERR_EN);

    in_valid = 1'b1;
    #1;
    chk("post_wr_en",   wr_en,   2'b01);
    chk("post_wr_addr", wr_addr, 0);
    @(negedge clk);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
